chu_gpo_seq: RTL and testbench
==============================

// Module: chu_gpo_seq
// PURPOSE
//  MMIO slot core that sequences a general-purpose output port through a table of up to D patterns.
//  Each pattern is held for a programmable dwell time; the sequence runs once or loops.
//  When the sequencer is idle, software can drive the port directly (manual mode).
//  Sits on the same slot bus as the plain GPO core; drives LEDs/pins in place of it.
// PARAMETERS
//  W   8   output port width (1..32)
//  D   16  pattern table depth (power of 2, 2..16)
//  DW  32  dwell counter width (1..32)
// PORTS
//  clk      in   1   system clock; single clock domain
//  reset_n  in   1   asynchronous, active-low reset
//  cs       in   1   slot select
//  read     in   1   read strobe (no read side effects; unused)
//  write    in   1   write strobe; register write when cs && write
//  addr     in   5   register address
//  wr_data  in   32  write data
//  rd_data  out  32  read data, combinational decode of addr
//  dout     out  W   external output port, registered
// BEHAVIOUR
//  Register map:
//   addr 0 CTRL, write:
//    b0 start, b1 stop, b2 loop, b3 clr_done, b4 irq_en
//    b2 and b4 are stored; b0, b1 and b3 are pulses
//   addr 0 STATUS, read: {busy[31], done[30], loop[29], irq_en[28], step[3:0]}
//   addr 1 DWELL: hold time per step = DWELL+1 cycles; read back
//   addr 2 LEN: step count, 1..D
//    stored value is wr_data[4:0]; 0 or a value >D stores D; read back
//   addr 3 MANUAL: writes load out_reg only in IDLE, ignored in RUN; reads return out_reg
//   addr 16..16+D-1 table entry pat[addr[3:0]] = wr_data[W-1:0]
//    writable in any state; zero-extended on read
//  Reset: state IDLE, out_reg=0 (dout=0), step=0, cnt=0, done=0
//   loop=0, irq_en=0, DWELL=0, LEN=D, pat[*]=0
//  FSM:
//   IDLE --start--> RUN: at the write edge, step<=0, cnt<=0, out_reg<=pat[0], done<=0
//    so dout=pat[0] from the next cycle
//   RUN, each cycle:
//    cnt!=DWELL: cnt++
//    cnt==DWELL, step<LEN-1: step++, cnt<=0, out_reg<=pat[step+1]
//    cnt==DWELL, step==LEN-1, loop=1: step<=0, cnt<=0, out_reg<=pat[0]
//    cnt==DWELL, step==LEN-1, loop=0: ->IDLE, done<=1, dout holds last pattern
//   RUN --stop--> IDLE: dout holds its value, done unchanged
//  Boundaries:
//   start and stop in the same write: stop wins
//   start while RUN: restart from step 0 with the same action as start in IDLE
//   DWELL and LEN writes while busy are ignored
//   a pat[] write during RUN is seen the next time that entry is loaded
//   the loop bit may change in RUN; it is sampled at the last-step boundary
//   clr_done clears done; a clr_done in the same cycle that done is set: set wins
//   DWELL=0: each step is held 1 cycle; LEN=1, loop=1: dout is constant at pat[0]
//   reset_n asserted mid-run: immediate return to reset values
// CONFIGURATION
//  GPO_SEQ_IRQ_EN defined:
//   adds port  irq  out  1
//   irq = done && irq_en, registered; level, cleared via clr_done
//  GPO_SEQ_IRQ_EN undefined:
//   no irq port; the irq_en bit is not stored and reads 0
// STRUCTURE
//  Package chu_gpo_seq_pkg holds:
//   state_t enum {IDLE, RUN}
//   register offsets CTRL/DWELL/LEN/MANUAL and TBL_BASE=16
//   CTRL bit positions
//  Sub-module chu_gpo_seq_tbl: D x W register file
//   one write port and two async read ports (sequencer, bus readback)
// TESTING
//  1 Reset: dout=0; STATUS reads 0; LEN reads D
//  2 One-shot:
//    pat0..2 = 0x01,0x02,0x04; LEN=3; DWELL=3; start
//    -> dout 0x01,0x02,0x04, 4 cycles each
//    -> then busy=0, done=1, dout stays 0x04
//  3 Loop:
//    same setup, loop=1
//    -> the 12-cycle pattern repeats
//    -> stop mid-step-1: dout stays 0x02, busy=0, done=0
//  4 Ignored writes:
//    MANUAL=0xAA in RUN -> no effect on dout
//    MANUAL=0xAA in IDLE -> dout=0xAA next cycle
//    DWELL write in RUN -> readback unchanged
//  5 Edge cases:
//    DWELL=0, LEN=1, loop=0 -> busy for exactly 1 cycle
//    start+stop in one write -> stays IDLE
//    reset_n low at cycle 5 of RUN -> all reset values
//  6 IRQ (GPO_SEQ_IRQ_EN defined):
//    irq_en=1, one-shot done -> irq=1
//    clr_done -> irq=0 next cycle

Source files
------------

// File: rtl/chu_gpo_seq_pkg.sv
// rtl/chu_gpo_seq_pkg.sv - shared types, register offsets and CTRL bit positions for the GPO sequencer
package chu_gpo_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_DWELL  = 5'd1;
  localparam logic [4:0] REG_LEN    = 5'd2;
  localparam logic [4:0] REG_MANUAL = 5'd3;
  localparam logic [4:0] TBL_BASE   = 5'd16;

  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_LOOP     = 2;
  localparam int CTRL_CLR_DONE = 3;
  localparam int CTRL_IRQ_EN   = 4;

  // A requested length of 0 or beyond the table depth means "use the whole table".
  function automatic logic [4:0] clamp_len(input logic [4:0] v, input int depth);
    if (v == 5'd0 || int'(v) > depth) return 5'(depth);
    return v;
  endfunction

endpackage

// File: rtl/chu_gpo_seq_if.sv
// rtl/chu_gpo_seq_if.sv - MMIO slot bus between the processor-side master and the sequencer core
interface chu_gpo_seq_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_gpo_seq_tbl.sv
// rtl/chu_gpo_seq_tbl.sv - D x W pattern register file, one write port and two async read ports
module chu_gpo_seq_tbl #(
  parameter int W  = 8,
  parameter int D  = 16,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] seq_raddr,
  output logic [W-1:0]  seq_rdata,
  input  logic [AW-1:0] bus_raddr,
  output logic [W-1:0]  bus_rdata
);

  logic [W-1:0] mem [D];

  // Pattern storage: cleared on reset, written from the bus in any sequencer state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign seq_rdata = mem[seq_raddr];
  assign bus_rdata = mem[bus_raddr];

endmodule

// File: rtl/chu_gpo_seq.sv
// rtl/chu_gpo_seq.sv - GPO pattern sequencer slot core; optional irq output under GPO_SEQ_IRQ_EN
module chu_gpo_seq
  import chu_gpo_seq_pkg::*;
#(
  parameter int W  = 8,
  parameter int D  = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  chu_gpo_seq_if.slave  bus,
  output logic [W-1:0]  dout
`ifdef GPO_SEQ_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int         AW      = $clog2(D);
  localparam logic [4:0] LEN_MAX = 5'(D);

  state_t        state_q, state_d;
  logic [4:0]    step_q, step_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_q, out_d;
  logic          done_q, done_d;
  logic [DW-1:0] dwell_q;
  logic [4:0]    len_q;
  logic          loop_q;
  logic          irq_en_q;

  logic          wr_en, ctrl_wr, dwell_wr, len_wr, manual_wr, tbl_hit, tbl_wr;
  logic          start_p, stop_p, clr_p;
  logic          dwell_hit, last_step;
  logic [AW-1:0] seq_raddr;
  logic [W-1:0]  seq_rdata, bus_rdata;
  logic          unused_bits;

  assign wr_en     = bus.cs && bus.write;
  assign ctrl_wr   = wr_en && (bus.addr == REG_CTRL);
  assign dwell_wr  = wr_en && (bus.addr == REG_DWELL);
  assign len_wr    = wr_en && (bus.addr == REG_LEN);
  assign manual_wr = wr_en && (bus.addr == REG_MANUAL);
  assign tbl_hit   = bus.addr[4] && ({1'b0, bus.addr[3:0]} < LEN_MAX);
  assign tbl_wr    = wr_en && tbl_hit;

  // Stop has priority, so start is only honoured when stop is absent from the same write.
  assign start_p = ctrl_wr && bus.wr_data[CTRL_START] && !bus.wr_data[CTRL_STOP];
  assign stop_p  = ctrl_wr && bus.wr_data[CTRL_STOP];
  assign clr_p   = ctrl_wr && bus.wr_data[CTRL_CLR_DONE];

  assign dwell_hit = (cnt_q == dwell_q);
  assign last_step = (step_q == len_q - 5'd1);

  // The sequencer port points at the entry loaded on the next boundary: 0 on (re)start or wrap.
  assign seq_raddr = (state_q == IDLE || start_p || last_step) ? '0 : AW'(step_q + 5'd1);

  assign unused_bits = ^{bus.read, bus.wr_data};

  chu_gpo_seq_tbl #(.W(W), .D(D), .AW(AW)) u_tbl (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (tbl_wr),
    .waddr     (bus.addr[AW-1:0]),
    .wdata     (bus.wr_data[W-1:0]),
    .seq_raddr (seq_raddr),
    .seq_rdata (seq_rdata),
    .bus_raddr (bus.addr[AW-1:0]),
    .bus_rdata (bus_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath decode; clr_done is applied first so a same-cycle set wins.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = done_q;
    if (clr_p) done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_p) begin
          state_d = RUN;
          step_d  = '0;
          cnt_d   = '0;
          out_d   = seq_rdata;
          done_d  = 1'b0;
        end else if (manual_wr) begin
          out_d = bus.wr_data[W-1:0];
        end
      end
      RUN: begin
        if (stop_p) begin
          state_d = IDLE;
        end else if (start_p) begin
          step_d = '0;
          cnt_d  = '0;
          out_d  = seq_rdata;
          done_d = 1'b0;
        end else if (!dwell_hit) begin
          cnt_d = cnt_q + DW'(1);
        end else if (!last_step) begin
          step_d = step_q + 5'd1;
          cnt_d  = '0;
          out_d  = seq_rdata;
        end else if (loop_q) begin
          step_d = '0;
          cnt_d  = '0;
          out_d  = seq_rdata;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      step_q <= step_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      done_q <= done_d;
    end
  end

  // Configuration registers; DWELL and LEN are frozen while a sequence is running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_q <= '0;
      len_q   <= LEN_MAX;
      loop_q  <= 1'b0;
    end else begin
      if (dwell_wr && state_q == IDLE) dwell_q <= bus.wr_data[DW-1:0];
      if (len_wr && state_q == IDLE)   len_q   <= clamp_len(bus.wr_data[4:0], D);
      if (ctrl_wr)                     loop_q  <= bus.wr_data[CTRL_LOOP];
    end
  end

`ifdef GPO_SEQ_IRQ_EN
  logic irq_en_d;
  assign irq_en_d = ctrl_wr ? bus.wr_data[CTRL_IRQ_EN] : irq_en_q;

  // Interrupt enable and level irq, registered from next-state values so clr_done drops it in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq      <= done_d && irq_en_d;
    end
  end
`else
  assign irq_en_q = 1'b0;
`endif

  // Register readback, purely combinational on addr.
  always_comb begin
    bus.rd_data = '0;
    if (tbl_hit) begin
      bus.rd_data = 32'(bus_rdata);
    end else begin
      case (bus.addr)
        REG_CTRL:   bus.rd_data = {(state_q == RUN), done_q, loop_q, irq_en_q, 24'd0, step_q[3:0]};
        REG_DWELL:  bus.rd_data = 32'(dwell_q);
        REG_LEN:    bus.rd_data = 32'(len_q);
        REG_MANUAL: bus.rd_data = 32'(out_q);
        default:    bus.rd_data = '0;
      endcase
    end
  end

  assign dout = out_q;

endmodule

// File: tb/tb_chu_gpo_seq.sv
// tb/tb_chu_gpo_seq.sv - directed self-checking bench for chu_gpo_seq with a dout scoreboard
module tb_chu_gpo_seq;
  import chu_gpo_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] dout;
`ifdef GPO_SEQ_IRQ_EN
  logic       irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] r;

  chu_gpo_seq_if bus();

  chu_gpo_seq #(.W(8), .D(16), .DW(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .dout    (dout)
`ifdef GPO_SEQ_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge, returns at the following falling edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
    #1;
    d = bus.rd_data;
    bus.cs = 1'b0; bus.read = 1'b0;
  endtask

  task automatic push_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic drain(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, {24'd0, dout}, {24'd0, e});
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int max);
    logic [31:0] s;
    int n;
    n = 0;
    rd(REG_CTRL, s);
    while (s[31] && n < max) begin
      @(negedge clk);
      rd(REG_CTRL, s);
      n++;
    end
    check("wait_idle_busy", {31'd0, s[31]}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    check("reset_dout", {24'd0, dout}, 32'h0);
    rd(REG_CTRL, r);  check("reset_status", r, 32'h0);
    rd(REG_LEN, r);   check("reset_len", r, 32'd16);
    rd(REG_DWELL, r); check("reset_dwell", r, 32'h0);
`ifdef GPO_SEQ_IRQ_EN
    check("reset_irq", {31'd0, irq}, 32'h0);
`endif
    @(negedge clk);

    // Table setup and zero-extended readback
    wr(TBL_BASE, 32'hFFFF_FF01);
    wr(TBL_BASE + 5'd1, 32'h02);
    wr(TBL_BASE + 5'd2, 32'h04);
    rd(TBL_BASE, r); check("tbl_readback", r, 32'h01);
    wr(REG_LEN, 32'd3);
    wr(REG_DWELL, 32'd3);

    // One-shot: 4 cycles per pattern, then idle holding the last one
    wr(REG_CTRL, 32'h1);
    push_n(8'h01, 4); push_n(8'h02, 4); push_n(8'h04, 4);
    drain("oneshot_dout");
    rd(REG_CTRL, r); check("oneshot_status", r, 32'h4000_0002);
    check("oneshot_hold", {24'd0, dout}, 32'h04);

    // Loop: two full periods, then stop one cycle into step 1
    wr(REG_CTRL, 32'h5);
    for (int p = 0; p < 2; p++) begin
      push_n(8'h01, 4); push_n(8'h02, 4); push_n(8'h04, 4);
    end
    push_n(8'h01, 4); push_n(8'h02, 1);
    drain("loop_dout");
    wr(REG_CTRL, 32'h6);
    check("stop_dout", {24'd0, dout}, 32'h02);
    rd(REG_CTRL, r); check("stop_status", r, 32'h2000_0001);
    @(negedge clk);
    check("stop_hold", {24'd0, dout}, 32'h02);
    wr(REG_CTRL, 32'h0);

    // Writes ignored while running, MANUAL honoured in IDLE
    wr(REG_CTRL, 32'h1);
    wr(REG_MANUAL, 32'hAA);
    check("manual_in_run", {24'd0, dout}, 32'h01);
    wr(REG_DWELL, 32'd7);
    rd(REG_DWELL, r); check("dwell_in_run", r, 32'd3);
    wr(REG_LEN, 32'd1);
    rd(REG_LEN, r); check("len_in_run", r, 32'd3);
    wait_idle(40);
    check("run_end_dout", {24'd0, dout}, 32'h04);
    wr(REG_MANUAL, 32'hAA);
    check("manual_idle", {24'd0, dout}, 32'hAA);
    rd(REG_MANUAL, r); check("manual_readback", r, 32'hAA);

    // LEN clamping
    wr(REG_LEN, 32'd0);
    rd(REG_LEN, r); check("len_zero", r, 32'd16);
    wr(REG_LEN, 32'd20);
    rd(REG_LEN, r); check("len_over", r, 32'd16);

    // DWELL=0, LEN=1: busy for exactly one cycle
    wr(REG_LEN, 32'd1);
    wr(REG_DWELL, 32'd0);
    wr(REG_CTRL, 32'h1);
    rd(REG_CTRL, r); check("short_busy", {31'd0, r[31]}, 32'h1);
    check("short_dout", {24'd0, dout}, 32'h01);
    @(negedge clk);
    rd(REG_CTRL, r); check("short_done", r, 32'h4000_0000);

    // DWELL=0, LEN=1, loop=1: constant pat[0]
    wr(REG_CTRL, 32'h5);
    push_n(8'h01, 4);
    drain("const_dout");
    rd(REG_CTRL, r); check("const_busy", {31'd0, r[31]}, 32'h1);
    wr(REG_CTRL, 32'h2);
    rd(REG_CTRL, r); check("const_stop", {31'd0, r[31]}, 32'h0);

    // start and stop together: stays IDLE
    wr(REG_CTRL, 32'h3);
    rd(REG_CTRL, r); check("start_stop", r, 32'h0);

    // Reset mid-run
    wr(REG_LEN, 32'd3);
    wr(REG_DWELL, 32'd3);
    wr(REG_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_dout", {24'd0, dout}, 32'h0);
    rd(REG_CTRL, r);  check("rst_status", r, 32'h0);
    rd(REG_LEN, r);   check("rst_len", r, 32'd16);
    rd(REG_DWELL, r); check("rst_dwell", r, 32'h0);
    rd(TBL_BASE, r);  check("rst_tbl", r, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef GPO_SEQ_IRQ_EN
    // Interrupt on one-shot completion, cleared by clr_done
    wr(TBL_BASE, 32'h01);
    wr(TBL_BASE + 5'd1, 32'h02);
    wr(TBL_BASE + 5'd2, 32'h04);
    wr(REG_LEN, 32'd3);
    wr(REG_DWELL, 32'd3);
    wr(REG_CTRL, 32'h11);
    check("irq_running", {31'd0, irq}, 32'h0);
    wait_idle(40);
    check("irq_set", {31'd0, irq}, 32'h1);
    rd(REG_CTRL, r); check("irq_status", r, 32'h5000_0002);
    wr(REG_CTRL, 32'h18);
    check("irq_clr", {31'd0, irq}, 32'h0);
    rd(REG_CTRL, r); check("irq_clr_status", r, 32'h1000_0002);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
